// File: rtl/counter_ud_monitor_pkg.sv
// Shared types and the one-step counter contract used by the up/down counter monitor.
package counter_ud_mon_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    HALT  = 2'd2
  } mon_state_e;

  localparam int unsigned CNT_MAX_W = 32;

  // Next count of a counter_ud of the given width, evaluated in a 32-bit container and masked.
  function automatic logic [CNT_MAX_W-1:0] cnt_next(
    input logic [CNT_MAX_W-1:0] count,
    input logic                 load_en,
    input logic [CNT_MAX_W-1:0] load,
    input logic                 down,
    input int unsigned          width
  );
    logic [CNT_MAX_W-1:0] mask;
    logic [CNT_MAX_W-1:0] nxt;
    mask = {CNT_MAX_W{1'b1}} >> (CNT_MAX_W - width);
    if (load_en)   nxt = load;
    else if (down) nxt = count - 32'd1;
    else           nxt = count + 32'd1;
    return nxt & mask;
  endfunction

endpackage

// File: rtl/counter_ud_monitor_sat_cnt.sv
// Saturating event counter with synchronous clear and asynchronous active-low reset.
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                 q <= '0;
    else if (clr)              q <= '0;
    else if (inc && q != '1)   q <= q + 1'b1;
  end

endmodule

// File: rtl/counter_ud_monitor.sv
// In-line checker for counter_ud: predicts each count from the observed one and logs
// mismatches, legal wraps and the first failing sample.
module counter_ud_monitor
  import counter_ud_mon_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int ERR_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load,
  input  logic             down,
  input  logic [WIDTH-1:0] count,
  input  logic             rollover,
  input  logic             clr,
  output logic             err,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] wrap_cnt,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_obs,
  output logic [1:0]       state
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  mon_state_e       state_q;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] exp_d;
  logic [WIDTH-1:0] exp_ref;
  logic [WIDTH-1:0] prev_count;
  logic             prev_load_en;
  logic             active;
  logic             cnt_bad;
  logic             rov_bad;
  logic             err_now;
  logic             up_wrap;
  logic             down_wrap;
  logic             wrap_now;

  // The INIT check is always against zero, whatever exp_q holds.
  assign active    = (state_q != HALT);
  assign exp_ref   = (state_q == INIT) ? '0 : exp_q;
  assign exp_d     = WIDTH'(cnt_next(32'(count), load_en, 32'(load), down, WIDTH));
  assign cnt_bad   = (count != exp_ref);
  assign rov_bad   = (rollover != (count == ALL_ONES));
  assign err_now   = active && (cnt_bad || rov_bad);
  assign up_wrap   = (prev_count == ALL_ONES) && (count == '0);
  assign down_wrap = (prev_count == '0) && (count == ALL_ONES);
  assign wrap_now  = (state_q == TRACK) && !err_now && !prev_load_en && (up_wrap || down_wrap);
  assign state     = state_q;

  // The model is rebuilt from the observed count every cycle, so one glitch costs one error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= INIT;
      exp_q        <= '0;
      prev_count   <= '0;
      prev_load_en <= 1'b0;
      err          <= 1'b0;
      err_pulse    <= 1'b0;
      first_exp    <= '0;
      first_obs    <= '0;
    end else if (clr) begin
      state_q      <= INIT;
      exp_q        <= '0;
      prev_count   <= '0;
      prev_load_en <= 1'b0;
      err          <= 1'b0;
      err_pulse    <= 1'b0;
      first_exp    <= '0;
      first_obs    <= '0;
    end else if (active) begin
      exp_q        <= exp_d;
      prev_count   <= count;
      prev_load_en <= load_en;
      err_pulse    <= err_now;
      if (err_now) begin
        err <= 1'b1;
        if (!err) begin
          first_exp <= exp_ref;
          first_obs <= count;
        end
      end
      state_q <= (err_now && STOP_ON_ERR) ? HALT : TRACK;
    end else begin
      err_pulse <= 1'b0;
    end
  end

  sat_cnt #(.W(ERR_W)) u_err_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr),
    .inc  (err_now),
    .q    (err_cnt)
  );

  sat_cnt #(.W(ERR_W)) u_wrap_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr),
    .inc  (wrap_now),
    .q    (wrap_cnt)
  );

endmodule

// File: tb/tb_counter_ud_monitor.sv
// Bench for counter_ud_monitor: a free-running and a halting monitor watch a behavioural
// counter_ud whose output can be corrupted; both are compared against a reference model.
module tb_counter_ud_monitor;

  logic       clk = 1'b0;
  logic       rstn;
  logic       load_en, down, clr;
  logic [3:0] load;
  logic [3:0] good_cnt;
  logic [3:0] count;
  logic       rollover;
  logic       fc_en, fr_en, fr_val;
  logic [3:0] fc_val;

  logic        err_w   [2];
  logic        pulse_w [2];
  logic [15:0] ecnt_w  [2];
  logic [15:0] wcnt_w  [2];
  logic [3:0]  fexp_w  [2];
  logic [3:0]  fobs_w  [2];
  logic [1:0]  st_w    [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int phase;
    bit err;
    bit pulse;
    int ecnt;
    int wcnt;
    int fexp;
    int fobs;
    int hcnt;
    bit hld;
    int hload;
    bit hdown;
  } mdl_t;
  mdl_t m [2];

  typedef struct {
    logic       le;
    logic [3:0] ld;
    logic       dn;
    int         ex_state;
    int         ex_pulse;
    int         ex_ecnt;
    int         ex_wcnt;
  } vec_t;

  always #5 clk = ~clk;

  // Behavioural counter_ud; it advances from its visible output so a forced value sticks.
  assign count    = fc_en ? fc_val : good_cnt;
  assign rollover = fr_en ? fr_val : (count == 4'hF);

  always @(posedge clk or negedge rstn) begin
    if (!rstn)        good_cnt <= 4'd0;
    else if (load_en) good_cnt <= load;
    else if (down)    good_cnt <= count - 4'd1;
    else              good_cnt <= count + 4'd1;
  end

  counter_ud_monitor #(.WIDTH(4), .ERR_W(16), .STOP_ON_ERR(1'b0)) u_dut (
    .clk(clk), .rstn(rstn), .load_en(load_en), .load(load), .down(down),
    .count(count), .rollover(rollover), .clr(clr),
    .err(err_w[0]), .err_pulse(pulse_w[0]), .err_cnt(ecnt_w[0]), .wrap_cnt(wcnt_w[0]),
    .first_exp(fexp_w[0]), .first_obs(fobs_w[0]), .state(st_w[0])
  );

  counter_ud_monitor #(.WIDTH(4), .ERR_W(16), .STOP_ON_ERR(1'b1)) u_halt (
    .clk(clk), .rstn(rstn), .load_en(load_en), .load(load), .down(down),
    .count(count), .rollover(rollover), .clr(clr),
    .err(err_w[1]), .err_pulse(pulse_w[1]), .err_cnt(ecnt_w[1]), .wrap_cnt(wcnt_w[1]),
    .first_exp(fexp_w[1]), .first_obs(fobs_w[1]), .state(st_w[1])
  );

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference: phase 0/1/2 = init/track/halt; expectation follows the counter contract directly.
  task automatic model_step(input int i);
    int  c, expect_v, nxt;
    bit  bad, wrap;
    c = int'(count);
    if (!rstn) begin
      m[i] = '{default: 0};
      return;
    end
    if (clr) begin
      m[i].phase = 0; m[i].err = 0; m[i].pulse = 0; m[i].ecnt = 0;
      m[i].wcnt = 0;  m[i].fexp = 0; m[i].fobs = 0;
      return;
    end
    if (m[i].phase == 2) begin
      m[i].pulse = 0;
      return;
    end
    if (m[i].hld)        nxt = m[i].hload;
    else if (m[i].hdown) nxt = (m[i].hcnt + 15) % 16;
    else                 nxt = (m[i].hcnt + 1) % 16;
    expect_v = (m[i].phase == 0) ? 0 : nxt;
    bad  = (c != expect_v) || (rollover != (c == 15));
    wrap = (m[i].phase == 1) && !bad && !m[i].hld &&
           ((m[i].hcnt == 15 && c == 0) || (m[i].hcnt == 0 && c == 15));
    m[i].pulse = bad;
    if (bad) begin
      if (!m[i].err) begin
        m[i].fexp = expect_v;
        m[i].fobs = c;
      end
      m[i].err = 1;
      if (m[i].ecnt < 65535) m[i].ecnt++;
    end
    if (wrap && m[i].wcnt < 65535) m[i].wcnt++;
    m[i].phase = (bad && i == 1) ? 2 : 1;
    m[i].hcnt  = c;
    m[i].hld   = load_en;
    m[i].hload = int'(load);
    m[i].hdown = down;
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m%0d.state", i),     int'(st_w[i]),    m[i].phase);
      chk($sformatf("m%0d.err", i),       int'(err_w[i]),   int'(m[i].err));
      chk($sformatf("m%0d.err_pulse", i), int'(pulse_w[i]), int'(m[i].pulse));
      chk($sformatf("m%0d.err_cnt", i),   int'(ecnt_w[i]),  m[i].ecnt);
      chk($sformatf("m%0d.wrap_cnt", i),  int'(wcnt_w[i]),  m[i].wcnt);
      chk($sformatf("m%0d.first_exp", i), int'(fexp_w[i]),  m[i].fexp);
      chk($sformatf("m%0d.first_obs", i), int'(fobs_w[i]),  m[i].fobs);
    end
  endtask

  task automatic check_output(input int i, input int st, input int e, input int p,
                              input int ec, input int wc);
    chk($sformatf("fixed m%0d.state", i),     int'(st_w[i]),    st);
    chk($sformatf("fixed m%0d.err", i),       int'(err_w[i]),   e);
    chk($sformatf("fixed m%0d.err_pulse", i), int'(pulse_w[i]), p);
    chk($sformatf("fixed m%0d.err_cnt", i),   int'(ecnt_w[i]),  ec);
    chk($sformatf("fixed m%0d.wrap_cnt", i),  int'(wcnt_w[i]),  wc);
  endtask

  task automatic check_first(input int i, input int fe, input int fo);
    chk($sformatf("fixed m%0d.first_exp", i), int'(fexp_w[i]), fe);
    chk($sformatf("fixed m%0d.first_obs", i), int'(fobs_w[i]), fo);
  endtask

  // One clock: model consumes the pre-edge view, DUT outputs are sampled 1 ns after the edge.
  task automatic apply_stimulus();
    #1;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    fc_en   = 1'b0;
    fr_en   = 1'b0;
    clr     = 1'b0;
    load_en = 1'b0;
    check_all();
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    #1;
    model_step(0);
    model_step(1);
    check_all();
    repeat (n) apply_stimulus();
  endtask

  vec_t tbl [6];

  initial begin
    tbl[0] = '{le: 1'b1, ld: 4'h3, dn: 1'b1, ex_state: 1, ex_pulse: 0, ex_ecnt: 0, ex_wcnt: 1};
    tbl[1] = '{le: 1'b0, ld: 4'h0, dn: 1'b1, ex_state: 1, ex_pulse: 0, ex_ecnt: 0, ex_wcnt: 1};
    tbl[2] = '{le: 1'b0, ld: 4'h0, dn: 1'b1, ex_state: 1, ex_pulse: 0, ex_ecnt: 0, ex_wcnt: 1};
    tbl[3] = '{le: 1'b0, ld: 4'h0, dn: 1'b1, ex_state: 1, ex_pulse: 0, ex_ecnt: 0, ex_wcnt: 1};
    tbl[4] = '{le: 1'b0, ld: 4'h0, dn: 1'b1, ex_state: 1, ex_pulse: 0, ex_ecnt: 0, ex_wcnt: 1};
    tbl[5] = '{le: 1'b0, ld: 4'h0, dn: 1'b1, ex_state: 1, ex_pulse: 0, ex_ecnt: 0, ex_wcnt: 2};

    rstn = 1'b1; load_en = 1'b0; load = 4'h0; down = 1'b0; clr = 1'b0;
    fc_en = 1'b0; fc_val = 4'h0; fr_en = 1'b0; fr_val = 1'b0;
    m[0] = '{default: 0};
    m[1] = '{default: 0};
    #2;

    // Reset state, then 20 idle up-counting cycles: one F->0 wrap.
    do_reset(2);
    for (int i = 0; i < 2; i++) begin
      check_output(i, 0, 0, 0, 0, 0);
      check_first(i, 0, 0);
    end
    rstn = 1'b1;
    repeat (20) apply_stimulus();
    for (int i = 0; i < 2; i++) check_output(i, 1, 0, 0, 0, 1);

    // Load 3 then count down through the 0->F wrap.
    foreach (tbl[k]) begin
      load_en = tbl[k].le;
      load    = tbl[k].ld;
      down    = tbl[k].dn;
      apply_stimulus();
      for (int i = 0; i < 2; i++)
        check_output(i, tbl[k].ex_state, 0, tbl[k].ex_pulse, tbl[k].ex_ecnt, tbl[k].ex_wcnt);
    end

    // Count reads 7 where 6 is predicted: one error, none on the following cycle.
    load_en = 1'b1; load = 4'h5; down = 1'b0;
    apply_stimulus();
    apply_stimulus();
    fc_en = 1'b1; fc_val = 4'h7;
    apply_stimulus();
    check_output(0, 1, 1, 1, 1, 2);
    check_first(0, 6, 7);
    check_output(1, 2, 1, 1, 1, 2);
    check_first(1, 6, 7);
    apply_stimulus();
    check_output(0, 1, 1, 0, 1, 2);
    check_output(1, 2, 1, 0, 1, 2);

    // clr while halted, loading 0 so the INIT check sees zero; tracking resumes next edge.
    clr = 1'b1; load_en = 1'b1; load = 4'h0;
    apply_stimulus();
    for (int i = 0; i < 2; i++) begin
      check_output(i, 0, 0, 0, 0, 0);
      check_first(i, 0, 0);
    end
    apply_stimulus();
    for (int i = 0; i < 2; i++) check_output(i, 1, 0, 0, 0, 0);

    // Rollover held low at count F, then further corruption.
    load_en = 1'b1; load = 4'hF;
    apply_stimulus();
    down = 1'b1; fr_en = 1'b1; fr_val = 1'b0;
    apply_stimulus();
    check_output(0, 1, 1, 1, 1, 0);
    check_first(0, 15, 15);
    check_output(1, 2, 1, 1, 1, 0);
    fc_en = 1'b1; fc_val = 4'h3;
    apply_stimulus();
    check_output(0, 1, 1, 1, 2, 0);
    check_first(0, 15, 15);
    check_output(1, 2, 1, 0, 1, 0);

    // Asynchronous reset mid-count at 9, then a clean INIT check on zero.
    load_en = 1'b1; load = 4'h9;
    apply_stimulus();
    chk("count before reset", int'(count), 9);
    do_reset(2);
    for (int i = 0; i < 2; i++) begin
      check_output(i, 0, 0, 0, 0, 0);
      check_first(i, 0, 0);
    end
    rstn = 1'b1; down = 1'b0;
    apply_stimulus();
    for (int i = 0; i < 2; i++) check_output(i, 1, 0, 0, 0, 0);

    // Randomised traffic with occasional corruption, clears and resets.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1);
        rstn = 1'b1;
      end else begin
        load_en = ($urandom_range(0, 9) == 0);
        load    = 4'($urandom);
        if ($urandom_range(0, 11) == 0) down = ~down;
        clr = ($urandom_range(0, 39) == 0);
        case ($urandom_range(0, 29))
          0: begin fc_en = 1'b1; fc_val = good_cnt ^ 4'($urandom_range(1, 15)); end
          1: begin fr_en = 1'b1; fr_val = (good_cnt != 4'hF); end
          default: ;
        endcase
        apply_stimulus();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_ud_monitor.md
# counter_ud_monitor

Synthesizable in-line checker that sits on the receiving end of the `cnt_if` up/down-counter interface, beside `counter_ud`. It watches the stimulus (`load_en`, `load`, `down`) and the counter's responses (`count`, `rollover`), and predicts each next count with a one-step model. It reports mismatches, counts errors and legal wraps, and captures the first failure for debug. It is instantiated in counter benches and optionally in FPGA builds as a self-check.

## Interface
- `WIDTH`, 4, counter width; must match the monitored `counter_ud`.
- `ERR_W`, 16, width of the error and wrap counters.
- `STOP_ON_ERR`, 0, when 1 the monitor freezes in HALT on the first error.

- `clk`  in  1  sole clock; all sampling is on the posedge.
- `rstn`  in  1  asynchronous active-low reset, shared with the DUT.
- `load_en`  in  1  observed load strobe.
- `load`  in  WIDTH  observed load value.
- `down`  in  1  observed direction (1 = decrement).
- `count`  in  WIDTH  observed counter output.
- `rollover`  in  1  observed rollover flag.
- `clr`  in  1  synchronous clear of status; returns the FSM to INIT.
- `err`  out  1  sticky error flag.
- `err_pulse`  out  1  one-cycle pulse per detected error.
- `err_cnt`  out  ERR_W  saturating error count.
- `wrap_cnt`  out  ERR_W  saturating count of legal wraps.
- `first_exp`  out  WIDTH  expected count at the first error.
- `first_obs`  out  WIDTH  observed count at the first error.
- `state`  out  2  FSM state: INIT=0, TRACK=1, HALT=2.

## Operation
- Counter contract under check:
  - at each posedge with `rstn`=1: `count` ← `load` if `load_en`; else `count-1` if `down`; else `count+1`.
  - arithmetic is modulo 2^WIDTH.
  - `rstn`=0 forces `count`=0.
  - `rollover` is combinational and equals (`count` == all-ones).
- Model register `exp`, updated at every posedge in INIT/TRACK:
  - computed from the *observed* `count` and the sampled inputs, using the contract above;
  - because it is rebuilt from observed values, one bad value produces exactly one error, not a cascade.
- FSM:
  - INIT: entered on reset or `clr`. At the first posedge with `rstn`=1, checks `count`==0, loads `exp`, goes to TRACK.
  - TRACK: at each posedge checks `count`==`exp`.
  - TRACK also checks `rollover`==(`count`==all-ones) in every cycle; both checks apply in INIT too.
  - Any failed check in INIT or TRACK is one error event, even when both checks fail in the same cycle.
  - On error with `STOP_ON_ERR`=1: INIT/TRACK → HALT.
  - HALT: no checks; `exp` and all counters frozen; leaves only via `clr` or reset.
- Error event:
  - `err_pulse`=1 for one cycle;
  - `err` set (sticky);
  - `err_cnt`+1, saturating at 2^ERR_W-1;
  - if `err` was 0: `first_exp`←`exp`, `first_obs`←`count`.
- Wrap event (TRACK only, no error in that cycle, previous cycle had `load_en`=0):
  - up wrap: previous count all-ones → now 0;
  - down wrap: previous count 0 → now all-ones;
  - either one increments `wrap_cnt`, saturating.
- `clr`:
  - has priority over checking in the same cycle;
  - zeroes `err`, `err_pulse`, both counters, `first_*`;
  - sets state to INIT.

## Timing
- Reset values: all outputs 0, state INIT, `exp`=0.
- Reset is asynchronous and may be asserted mid-operation; it aborts any in-flight check with no error recorded.
- Latency: a bad `count` sampled at posedge k drives `err_pulse` from posedge k to posedge k+1. `err_cnt`, `err` and `first_*` update at the same edge.
- After reset release, the check at the first posedge (INIT) compares against 0; prediction begins on the following edge.
- Inputs are sampled at the same posedge the DUT uses; no combinational path exists from any input to any output.

## Structure
- Package `counter_ud_mon_pkg`:
  - `mon_state_e` enum (INIT, TRACK, HALT);
  - function `cnt_next(count, load_en, load, down)`, parameterized through a WIDTH argument or a class-less mask.
- One sub-module: `sat_cnt #(W)`, a saturating incrementer with sync clear and async reset. It is instantiated twice, for `err_cnt` and `wrap_cnt`.

## Test plan
- Reset, then release `rstn` with inputs idle against a good `counter_ud` for 20 cycles → `state`=TRACK, `err`=0, `wrap_cnt`=1 (0xF→0x0 after 16 increments).
- `load_en`=1, `load`=0x3, then `down`=1 for 5 cycles → counts 3,2,1,0,F checked, `wrap_cnt`+1, no error.
- Force the DUT's `count` to 0x7 where 0x6 is expected, for one cycle → a single `err_pulse`, `err_cnt`=1, `first_exp`=0x6, `first_obs`=0x7; the next cycle has no error.
- Force `rollover`=0 while `count`=0xF → error event; with `STOP_ON_ERR`=1, `state`=HALT and further corruption leaves `err_cnt`=1.
- Pulse `clr` in HALT → all status is 0, state INIT, and tracking resumes on the next edge.
- Assert `rstn` low mid-count (`count`=0x9) for 2 cycles → outputs are 0 asynchronously; after release, the INIT check passes on `count`=0.
